// File: rtl/dbus_stream_pkg.sv
// Shared constants for the data-bus stream responder: register offsets,
// STATUS/CONTROL bit positions and the default window base address.
package dbus_stream_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFF20_0100;

    // Word offsets inside the 16-byte window (iAddress[3:2])
    localparam logic [1:0] OFS_TXDATA  = 2'd0;
    localparam logic [1:0] OFS_RXDATA  = 2'd1;
    localparam logic [1:0] OFS_STATUS  = 2'd2;
    localparam logic [1:0] OFS_CONTROL = 2'd3;

    // STATUS bit positions
    localparam int STS_TX_FULL   = 0;
    localparam int STS_TX_EMPTY  = 1;
    localparam int STS_RX_FULL   = 2;
    localparam int STS_RX_EMPTY  = 3;
    localparam int STS_TX_OVF    = 4;
    localparam int STS_RX_UNF    = 5;
    localparam int STS_TX_COUNT  = 8;
    localparam int STS_RX_COUNT  = 16;

    // CONTROL bit positions
    localparam int CTRL_TX_IRQ_EN = 0;
    localparam int CTRL_RX_IRQ_EN = 1;
    localparam int CTRL_FLUSH     = 2;

    // Occupancy as an 8-bit STATUS field. Only a 256-deep FIFO can reach
    // 256, which cannot be shown in 8 bits, so it saturates at 0xFF.
    function automatic logic [7:0] countField(input logic [8:0] count);
        return count[8] ? 8'hFF : count[7:0];
    endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Show-ahead synchronous FIFO: head word is visible whenever not empty.
// Push into a full FIFO only lands when a pop happens in the same cycle;
// flush empties it and overrides any same-cycle push or pop.
module stream_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iPushData,
    input  logic             iPop,
    input  logic             iFlush,
    output logic [WIDTH-1:0] oHead,
    output logic             oFull,
    output logic             oEmpty,
    output logic             oEmptyNext,
    output logic [AW:0]      oCount
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic [AW:0]      countNext;
    logic             doPush;
    logic             doPop;

    assign oFull  = (count == FULL_COUNT);
    assign oEmpty = (count == '0);
    assign oCount = count;
    assign oHead  = mem[rdPtr];

    assign doPop  = iPop & ~oEmpty;
    assign doPush = iPush & (~oFull | doPop);

    // Occupancy after this edge; flush wins over everything else
    always_comb begin
        countNext = count;
        if (iFlush) begin
            countNext = '0;
        end else if (doPush && !doPop) begin
            countNext = count + 1'b1;
        end else if (doPop && !doPush) begin
            countNext = count - 1'b1;
        end
    end

    assign oEmptyNext = (countNext == '0);

    // Pointer and occupancy registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            count <= countNext;
            if (iFlush) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (doPush) wrPtr <= wrPtr + 1'b1;
                if (doPop)  rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    // Storage; when full with a same-cycle pop the write reuses the slot
    // being vacated, whose old contents were already presented on oHead
    always_ff @(posedge iCLK) begin
        if (doPush && !iFlush) mem[wrPtr] <= iPushData;
    end

endmodule

// File: rtl/dbus_stream_responder.sv
// CPU data-bus responder bridging loads/stores to a TX and an RX word stream.
// Reads are answered combinationally in the same cycle; writes act on the
// clock edge. Holds address decode, CONTROL, sticky error flags and the IRQ.
module dbus_stream_responder
    import dbus_stream_pkg::*;
#(
    parameter  logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter  int          DEPTH     = 8,
    localparam int          AW        = $clog2(DEPTH)
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iReadEnable,
    input  logic        iWriteEnable,
    input  logic [3:0]  iByteEnable,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic [31:0] oReadData,
    output logic        oHit,
    output logic [31:0] oTxData,
    output logic        oTxValid,
    input  logic        iTxReady,
    input  logic [31:0] iRxData,
    input  logic        iRxValid,
    output logic        oRxReady,
    output logic        oIRQ
);

    logic [1:0]  offset;
    logic        wrHit;
    logic        rdHit;
    logic        unusedAddrBits;

    logic        txPushReq;
    logic [31:0] txPushData;
    logic        txPop;
    logic        txFull;
    logic        txEmpty;
    logic        txEmptyNext;
    logic [AW:0] txCount;

    logic        rxReadReq;
    logic        rxPop;
    logic        rxPush;
    logic [31:0] rxHead;
    logic        rxFull;
    logic        rxEmpty;
    logic        rxEmptyNext;
    logic [AW:0] rxCount;

    logic        ctrlWr;
    logic        statusWr;
    logic        flush;

    logic        txOvf;
    logic        rxUnf;
    logic        txIrqEn;
    logic        rxIrqEn;
    logic        txOvfSet;
    logic        rxUnfSet;
    logic        txOvfNext;
    logic        rxUnfNext;
    logic        txIrqEnNext;
    logic        rxIrqEnNext;
    logic        irqNext;

    logic [31:0] statusWord;
    logic [31:0] readMux;

    assign offset         = iAddress[3:2];
    assign unusedAddrBits = ^iAddress[1:0];
    assign oHit           = (iAddress[31:4] == BASE_ADDR[31:4]);
    assign wrHit          = oHit & iWriteEnable;
    assign rdHit          = oHit & iReadEnable;

    assign txPushReq = wrHit & (offset == OFS_TXDATA) & (|iByteEnable);
    assign txPop     = iTxReady & ~txEmpty;
    assign txOvfSet  = txPushReq & txFull & ~txPop;

    assign rxReadReq = rdHit & (offset == OFS_RXDATA);
    assign rxPop     = rxReadReq & ~rxEmpty;
    assign rxUnfSet  = rxReadReq & rxEmpty;
    assign rxPush    = iRxValid & ~rxFull;

    assign ctrlWr   = wrHit & (offset == OFS_CONTROL) & iByteEnable[0];
    assign statusWr = wrHit & (offset == OFS_STATUS) & iByteEnable[0];
    assign flush    = ctrlWr & iWriteData[CTRL_FLUSH];

    // Disabled byte lanes are stored as zero
    always_comb begin
        txPushData = '0;
        for (int lane = 0; lane < 4; lane++) begin
            if (iByteEnable[lane]) txPushData[lane*8 +: 8] = iWriteData[lane*8 +: 8];
        end
    end

    stream_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) uTxFifo (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iPush      (txPushReq),
        .iPushData  (txPushData),
        .iPop       (txPop),
        .iFlush     (flush),
        .oHead      (oTxData),
        .oFull      (txFull),
        .oEmpty     (txEmpty),
        .oEmptyNext (txEmptyNext),
        .oCount     (txCount)
    );

    stream_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) uRxFifo (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iPush      (rxPush),
        .iPushData  (iRxData),
        .iPop       (rxPop),
        .iFlush     (flush),
        .oHead      (rxHead),
        .oFull      (rxFull),
        .oEmpty     (rxEmpty),
        .oEmptyNext (rxEmptyNext),
        .oCount     (rxCount)
    );

    assign oTxValid = ~txEmpty;
    assign oRxReady = ~rxFull;

    // Next values of sticky flags, enables and the interrupt request
    always_comb begin
        txOvfNext   = (txOvf & ~(statusWr & iWriteData[STS_TX_OVF])) | txOvfSet;
        rxUnfNext   = (rxUnf & ~(statusWr & iWriteData[STS_RX_UNF])) | rxUnfSet;
        txIrqEnNext = ctrlWr ? iWriteData[CTRL_TX_IRQ_EN] : txIrqEn;
        rxIrqEnNext = ctrlWr ? iWriteData[CTRL_RX_IRQ_EN] : rxIrqEn;
        irqNext     = (txIrqEnNext & txEmptyNext) | (rxIrqEnNext & ~rxEmptyNext)
                    | txOvfNext | rxUnfNext;
    end

    // CSR, sticky flag and IRQ registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            txOvf   <= 1'b0;
            rxUnf   <= 1'b0;
            txIrqEn <= 1'b0;
            rxIrqEn <= 1'b0;
            oIRQ    <= 1'b0;
        end else begin
            txOvf   <= txOvfNext;
            rxUnf   <= rxUnfNext;
            txIrqEn <= txIrqEnNext;
            rxIrqEn <= rxIrqEnNext;
            oIRQ    <= irqNext;
        end
    end

    // STATUS word assembled from live FIFO state
    always_comb begin
        statusWord                          = '0;
        statusWord[STS_TX_FULL]             = txFull;
        statusWord[STS_TX_EMPTY]            = txEmpty;
        statusWord[STS_RX_FULL]             = rxFull;
        statusWord[STS_RX_EMPTY]            = rxEmpty;
        statusWord[STS_TX_OVF]              = txOvf;
        statusWord[STS_RX_UNF]              = rxUnf;
        statusWord[STS_TX_COUNT +: 8]       = countField(9'(txCount));
        statusWord[STS_RX_COUNT +: 8]       = countField(9'(rxCount));
    end

    // Same-cycle read data, forced to zero unless this window is read
    always_comb begin
        readMux = '0;
        unique case (offset)
            OFS_TXDATA:  readMux = '0;
            OFS_RXDATA:  readMux = rxEmpty ? '0 : rxHead;
            OFS_STATUS:  readMux = statusWord;
            OFS_CONTROL: begin
                readMux[CTRL_TX_IRQ_EN] = txIrqEn;
                readMux[CTRL_RX_IRQ_EN] = rxIrqEn;
            end
            default:     readMux = '0;
        endcase
        oReadData = rdHit ? readMux : '0;
    end

endmodule

// File: tb/tb_dbus_stream_responder.sv
// Scoreboard bench: the driver computes expected outputs from a queue-based
// model of the register map and pushes them; a negedge monitor compares.
module tb_dbus_stream_responder;

    localparam logic [31:0] BASE  = 32'hFF20_0100;
    localparam int          DEPTH = 8;

    logic        iCLK;
    logic        iRST_N;
    logic        iReadEnable;
    logic        iWriteEnable;
    logic [3:0]  iByteEnable;
    logic [31:0] iAddress;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;
    logic        oHit;
    logic [31:0] oTxData;
    logic        oTxValid;
    logic        iTxReady;
    logic [31:0] iRxData;
    logic        iRxValid;
    logic        oRxReady;
    logic        oIRQ;

    dbus_stream_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
        .iByteEnable(iByteEnable), .iAddress(iAddress), .iWriteData(iWriteData),
        .oReadData(oReadData), .oHit(oHit),
        .oTxData(oTxData), .oTxValid(oTxValid), .iTxReady(iTxReady),
        .iRxData(iRxData), .iRxValid(iRxValid), .oRxReady(oRxReady),
        .oIRQ(oIRQ)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        hit;
        logic        txValid;
        logic [31:0] txHead;
        logic        rxReady;
        logic        irq;
        logic [31:0] rdata;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] sinkQ[$];

    // reference model state
    logic [31:0] mTx[$];
    logic [31:0] mRx[$];
    logic        mOvf, mUnf, mTxEn, mRxEn, mIrq;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic modelReset();
        mTx.delete(); mRx.delete(); sinkQ.delete();
        mOvf = 0; mUnf = 0; mTxEn = 0; mRxEn = 0; mIrq = 0;
    endtask

    function automatic logic [31:0] modelRead(input logic [1:0] off);
        int txN = mTx.size();
        int rxN = mRx.size();
        logic [31:0] v = '0;
        case (off)
            2'd1: v = (rxN > 0) ? mRx[0] : 32'h0;
            2'd2: begin
                v[0] = (txN == DEPTH); v[1] = (txN == 0);
                v[2] = (rxN == DEPTH); v[3] = (rxN == 0);
                v[4] = mOvf; v[5] = mUnf;
                v[15:8] = 8'(txN); v[23:16] = 8'(rxN);
            end
            2'd3: v = {30'b0, mRxEn, mTxEn};
            default: v = '0;
        endcase
        return v;
    endfunction

    // Record expectations for the current cycle, advance the model across
    // the coming edge, then move to just after that edge.
    task automatic step();
        exp_t e;
        int txN = mTx.size();
        int rxN = mRx.size();
        logic hit = (iAddress[31:4] == BASE[31:4]);
        logic [1:0] off = iAddress[3:2];
        logic [31:0] masked;
        logic flush, txPush, txPop, rxRead, rxPush;
        e.hit = hit;
        e.txValid = (txN > 0);
        e.txHead = (txN > 0) ? mTx[0] : 32'h0;
        e.rxReady = (rxN < DEPTH);
        e.irq = mIrq;
        e.rdata = (iReadEnable && hit) ? modelRead(off) : 32'h0;
        expQ.push_back(e);

        flush  = iWriteEnable && hit && off == 2'd3 && iByteEnable[0] && iWriteData[2];
        txPush = iWriteEnable && hit && off == 2'd0 && (iByteEnable != 4'h0);
        txPop  = iTxReady && txN > 0;
        rxRead = iReadEnable && hit && off == 2'd1;
        rxPush = iRxValid && rxN < DEPTH;
        for (int b = 0; b < 4; b++)
            masked[b*8 +: 8] = iByteEnable[b] ? iWriteData[b*8 +: 8] : 8'h00;

        if (txPop) sinkQ.push_back(mTx[0]);
        if (txPush && txN == DEPTH && !txPop) mOvf = 1;
        if (rxRead && rxN == 0) mUnf = 1;
        if (flush) begin
            mTx.delete(); mRx.delete();
        end else begin
            if (txPop) void'(mTx.pop_front());
            if (txPush && (txN < DEPTH || txPop)) mTx.push_back(masked);
            if (rxRead && rxN > 0) void'(mRx.pop_front());
            if (rxPush) mRx.push_back(iRxData);
        end
        if (iWriteEnable && hit && off == 2'd2 && iByteEnable[0]) begin
            if (iWriteData[4] && !(txPush && txN == DEPTH && !txPop)) mOvf = 0;
            if (iWriteData[5] && !(rxRead && rxN == 0)) mUnf = 0;
        end
        if (iWriteEnable && hit && off == 2'd3 && iByteEnable[0]) begin
            mTxEn = iWriteData[0];
            mRxEn = iWriteData[1];
        end
        mIrq = (mTxEn && mTx.size() == 0) || (mRxEn && mRx.size() != 0) || mOvf || mUnf;

        @(posedge iCLK); #1;
    endtask

    task automatic idleBus();
        iReadEnable = 0; iWriteEnable = 0; iByteEnable = 4'h0;
        iAddress = 32'h0; iWriteData = 32'h0;
    endtask

    task automatic busWrite(input logic [3:0] ofs, input logic [3:0] be, input logic [31:0] d);
        iWriteEnable = 1; iReadEnable = 0; iByteEnable = be;
        iAddress = BASE + {28'h0, ofs}; iWriteData = d;
        step();
        idleBus();
    endtask

    task automatic busRead(input logic [3:0] ofs);
        iReadEnable = 1; iWriteEnable = 0; iByteEnable = 4'h0;
        iAddress = BASE + {28'h0, ofs};
        step();
        idleBus();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rxInject(input logic [31:0] d);
        iRxValid = 1; iRxData = d;
        step();
        iRxValid = 0;
    endtask

    // Monitor: pops one expectation per driven cycle and compares outputs
    always @(negedge iCLK) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk("hit", {31'b0, oHit}, {31'b0, e.hit});
            chk("tx_valid", {31'b0, oTxValid}, {31'b0, e.txValid});
            chk("rx_ready", {31'b0, oRxReady}, {31'b0, e.rxReady});
            chk("irq", {31'b0, oIRQ}, {31'b0, e.irq});
            chk("read_data", oReadData, e.rdata);
            if (e.txValid) chk("tx_head", oTxData, e.txHead);
            if (oTxValid && iTxReady) begin
                if (sinkQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sink_unexpected actual=%h required=none", oTxData);
                end else begin
                    chk("sink_word", oTxData, sinkQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] rofs;
        iRST_N = 0; iTxReady = 0; iRxValid = 0; iRxData = 32'h0;
        idleBus();
        modelReset();
        repeat (3) @(posedge iCLK);
        #1 iRST_N = 1;

        // reset state and a first TX push held by a stalled sink
        busRead(4'h8);
        busWrite(4'h0, 4'hF, 32'hA5A5_A5A5);
        busRead(4'h8);
        busWrite(4'hC, 4'h1, 32'h4);

        // overflow on the ninth push, then clear via write-1-to-clear
        for (int k = 0; k < 9; k++) busWrite(4'h0, 4'hF, 32'h100 + k);
        idle(1);
        busRead(4'h8);
        busWrite(4'h8, 4'h1, 32'h10);
        busRead(4'h8);
        busWrite(4'hC, 4'h1, 32'h4);

        // streaming with sink always ready, including partial byte lanes
        iTxReady = 1;
        for (int k = 1; k <= 8; k++) busWrite(4'h0, 4'hF, k);
        busWrite(4'h0, 4'h5, 32'hDEAD_BEEF);
        idle(3);
        busRead(4'h8);
        iTxReady = 0;

        // RX order and underflow
        rxInject(32'h11);
        rxInject(32'h22);
        busRead(4'h4);
        busRead(4'h4);
        busRead(4'h4);
        busRead(4'h8);
        busWrite(4'h8, 4'h1, 32'h20);

        // RX interrupt follows occupancy
        busWrite(4'hC, 4'h1, 32'h2);
        rxInject(32'h33);
        idle(1);
        busRead(4'h4);
        idle(2);
        busWrite(4'hC, 4'h1, 32'h0);

        // flush of two full FIFOs with same-cycle stream traffic
        for (int k = 0; k < DEPTH; k++) busWrite(4'h0, 4'hF, 32'hC0 + k);
        for (int k = 0; k < DEPTH; k++) rxInject(32'hD0 + k);
        iTxReady = 1; iRxValid = 1; iRxData = 32'hEE;
        busWrite(4'hC, 4'h1, 32'h4);
        iTxReady = 0; iRxValid = 0;
        busRead(4'h8);

        // randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                iRST_N = 0;
                modelReset();
                idleBus(); iTxReady = 0; iRxValid = 0;
                repeat (2) @(posedge iCLK);
                #1 iRST_N = 1;
            end
            iTxReady = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            iRxValid = ($urandom_range(0, 2) == 0);
            iRxData = $urandom;
            rofs = {$urandom_range(0, 3), 2'($urandom_range(0, 3))};
            iAddress = ($urandom_range(0, 7) == 0) ? (BASE + 32'h10 + {28'h0, rofs}) : (BASE + {28'h0, rofs});
            iReadEnable = $urandom_range(0, 1);
            iWriteEnable = $urandom_range(0, 1);
            iByteEnable = 4'($urandom_range(0, 15));
            iWriteData = $urandom;
            if (iAddress[3:2] == 2'd3 && $urandom_range(0, 7) != 0) iWriteData[2] = 1'b0;
            step();
        end
        idleBus(); iTxReady = 0; iRxValid = 0;
        idle(2);
        @(negedge iCLK); #1;
        chk("scoreboard_drained", expQ.size(), 0);
        chk("sink_drained", sinkQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
